posit_divsqrt_ctrl: RTL

Initiator-side controller for the posit div/sqrt unit. It accepts operation requests from the core, issues them to the unit over the unit's in_valid/in_ready handshake, and maps the unit's 1-bit tag onto a 2-entry in-flight table holding core tags. It collects results over out_valid/out_ready into a registered response port and accumulates sticky status flags. It sits between the core's posit dispatch stage and the div/sqrt unit.

---
 rtl/posit_pkg.sv | 26 ++
 rtl/posit_divsqrt_slot_table.sv | 31 +++
 rtl/posit_divsqrt_ctrl.sv | 100 ++++++++++
 3 files changed

// File: rtl/posit_pkg.sv
// posit_pkg: posit formats, div/sqrt operation types, status flags and controller slot types
package posit_pkg;
  typedef enum logic [1:0] {POSIT16, POSIT8, POSIT32} posit_format_e;
  typedef enum logic {DIV, SQRT} operation_e;
  typedef enum logic [2:0] {RNE, RTZ, RDN, RUP, RMM} roundmode_e;
  typedef struct packed {
    logic nv;
    logic dz;
    logic of;
    logic uf;
    logic nx;
  } status_t;
  localparam int unsigned CTRL_SLOTS = 2;
  localparam int unsigned CTRL_TAG_W = 5;
  typedef struct packed {
    logic                  vld;
    logic [CTRL_TAG_W-1:0] tag;
  } ctrl_slot_t;
  localparam status_t STATUS_NV = '{nv: 1'b1, default: 1'b0};
  function automatic int unsigned posit_width(posit_format_e f);
    return f == POSIT8 ? 32'd8 : f == POSIT32 ? 32'd32 : 32'd16;
  endfunction
  function automatic logic [31:0] posit_nar(posit_format_e f);
    return 32'd1 << (posit_width(f) - 32'd1);
  endfunction
endpackage

// File: rtl/posit_divsqrt_slot_table.sv
// posit_divsqrt_slot_table: 2-entry in-flight core-tag table with issue and return pointers
module posit_divsqrt_slot_table import posit_pkg::*; #(
  parameter int unsigned TAG_W = 5
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             set,
  input  logic [TAG_W-1:0]                 set_tag,
  input  logic                             clr,
  input  logic                             clr_idx,
  input  logic                             kill,
  output logic [CTRL_SLOTS-1:0]            vld,
  output logic [CTRL_SLOTS-1:0]            vld_nxt,
  output logic [CTRL_SLOTS-1:0][TAG_W-1:0] tags,
  output logic                             iss_ptr,
  output logic                             ret_ptr
);
  always_comb vld_nxt = kill ? '0 : (vld & ~(clr ? CTRL_SLOTS'(1) << clr_idx : '0)) | (set ? CTRL_SLOTS'(1) << iss_ptr : '0);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      vld     <= '0;
      tags    <= '0;
      iss_ptr <= 1'b0;
      ret_ptr <= 1'b0;
    end else begin
      vld     <= vld_nxt;
      if (set) tags[iss_ptr] <= set_tag;
      iss_ptr <= kill ? 1'b0 : iss_ptr ^ set;
      ret_ptr <= kill ? 1'b0 : ret_ptr ^ clr;
    end
endmodule

// File: rtl/posit_divsqrt_ctrl.sv
// posit_divsqrt_ctrl: core-side issue/return controller for the posit div/sqrt unit (watchdog via POSIT_DIVSQRT_TIMEOUT_EN)
module posit_divsqrt_ctrl import posit_pkg::*; #(
  parameter posit_format_e pFormat        = posit_format_e'(0),
  parameter int unsigned   TAG_W          = 5,
  parameter int unsigned   TIMEOUT_CYCLES = 64,
  localparam int unsigned  WIDTH          = posit_width(pFormat)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [1:0][WIDTH-1:0] req_operands_i,
  input  operation_e            req_op_i,
  input  roundmode_e            req_rnd_mode_i,
  input  logic [TAG_W-1:0]      req_tag_i,
  input  logic                  flush_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [WIDTH-1:0]      rsp_result_o,
  output status_t               rsp_status_o,
  output logic [TAG_W-1:0]      rsp_tag_o,
  output status_t               status_acc_o,
  input  logic                  clr_status_i,
  output logic                  busy_o,
  output logic [1:0][WIDTH-1:0] unit_operands_o,
  output operation_e            unit_op_o,
  output roundmode_e            unit_rnd_mode_o,
  output logic                  unit_tag_o,
  output logic                  unit_in_valid_o,
  input  logic                  unit_in_ready_i,
  output logic                  unit_flush_o,
  input  logic [WIDTH-1:0]      unit_result_i,
  input  status_t               unit_status_i,
  input  logic                  unit_tag_i,
  input  logic                  unit_out_valid_i,
  output logic                  unit_out_ready_o
);
  logic [CTRL_SLOTS-1:0]            vld, vld_nxt;
  logic [CTRL_SLOTS-1:0][TAG_W-1:0] tags;
  logic iss_ptr, ret_ptr, fire, kill, iss_hs, ret_hs, hit, rd_idx, rsp_valid_nxt;
  if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be nonzero");
  end
  assign kill             = flush_i | fire;
  assign req_ready_o      = unit_in_ready_i & ~vld[iss_ptr] & ~kill;
  assign unit_in_valid_o  = req_valid_i & ~vld[iss_ptr] & ~kill;
  assign iss_hs           = req_valid_i & req_ready_o;
  assign unit_operands_o  = req_operands_i;
  assign unit_op_o        = req_op_i;
  assign unit_rnd_mode_o  = req_rnd_mode_i;
  assign unit_tag_o       = iss_ptr;
  assign unit_flush_o     = kill;
  assign unit_out_ready_o = ~rsp_valid_o | rsp_ready_i;
  assign ret_hs           = unit_out_valid_i & unit_out_ready_o;
  assign hit              = ret_hs & vld[unit_tag_i] & ~flush_i;
  assign rd_idx           = fire ? ret_ptr : unit_tag_i;
  assign rsp_valid_nxt    = ~flush_i & (hit | fire | (rsp_valid_o & ~rsp_ready_i));
`ifdef POSIT_DIVSQRT_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] wd_cnt;
  assign fire = (wd_cnt >= CW'(TIMEOUT_CYCLES)) & ~ret_hs & unit_out_ready_o & ~flush_i;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) wd_cnt <= '0;
    else wd_cnt <= (ret_hs | kill | ~|vld) ? '0 : wd_cnt + CW'(wd_cnt < CW'(TIMEOUT_CYCLES));
`else
  assign fire = 1'b0;
`endif
  posit_divsqrt_slot_table #(.TAG_W(TAG_W)) u_table (
    .clk     (clk_i),
    .rst_n   (rst_ni),
    .set     (iss_hs),
    .set_tag (req_tag_i),
    .clr     (hit),
    .clr_idx (unit_tag_i),
    .kill    (kill),
    .vld     (vld),
    .vld_nxt (vld_nxt),
    .tags    (tags),
    .iss_ptr (iss_ptr),
    .ret_ptr (ret_ptr)
  );
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      rsp_valid_o  <= 1'b0;
      rsp_result_o <= '0;
      rsp_status_o <= '0;
      rsp_tag_o    <= '0;
      status_acc_o <= '0;
      busy_o       <= 1'b0;
    end else begin
      rsp_valid_o  <= rsp_valid_nxt;
      busy_o       <= |vld_nxt | rsp_valid_nxt;
      if (hit | fire) begin
        rsp_result_o <= fire ? WIDTH'(posit_nar(pFormat)) : unit_result_i;
        rsp_status_o <= fire ? STATUS_NV : unit_status_i;
        rsp_tag_o    <= tags[rd_idx];
      end
      status_acc_o <= status_t'((clr_status_i ? '0 : status_acc_o) | (rsp_valid_o & rsp_ready_i ? rsp_status_o : '0));
    end
endmodule
